// File: rtl/pipelined_64_bit_cla_subtractor.sv
// Two-stage pipelined 64-bit subtractor: diff = a - b - bin, built as a + ~b + ~bin on
// 16-bit carry look-ahead slices made of 4-bit groups. Stage 1 resolves the low 32 bits
// and the carry into bit 32; stage 2 resolves the upper 32 bits and the flags.
// Valid/ready on both sides; in_ready is combinational from out_ready (no skid buffer).
//
// Optional build macro CLA_ADD_MODE_EN adds an `op` input captured with the operands;
// op=1 selects addition (diff = a + b + bin) and bout then reports the raw carry out.
//
// Only WIDTH=64 / LO_WIDTH=32 is supported: the slice functions are fixed at 32 bits.
module pipelined_64_bit_cla_subtractor #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned LO_WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
`ifdef CLA_ADD_MODE_EN
  input  logic             op,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned HI_WIDTH = WIDTH - LO_WIDTH;

  // Carries into each bit of a 4-bit group, given the group's carry in.
  function automatic logic [3:0] cla4_carry(input logic [3:0] p, input logic [3:0] g,
                                            input logic c0);
    logic [3:0] c;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    return c;
  endfunction

  // Group generate/propagate of four bits (or four groups): {gen, prop}.
  function automatic logic [1:0] cla4_group(input logic [3:0] p, input logic [3:0] g);
    logic gg;
    logic gp;
    gp = &p;
    gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    return {gg, gp};
  endfunction

  // 16-bit CLA slice: four 4-bit groups with a second look-ahead level across groups.
  // Returns {carry_out, sum[15:0]}.
  function automatic logic [16:0] cla16(input logic [15:0] x, input logic [15:0] y,
                                        input logic cin);
    logic [15:0] p;
    logic [15:0] g;
    logic [15:0] c;
    logic [3:0]  gp;
    logic [3:0]  gg;
    logic [3:0]  gc;
    logic [1:0]  blk;
    p = x ^ y;
    g = x & y;
    for (int k = 0; k < 4; k++) begin
      blk   = cla4_group(p[4*k +: 4], g[4*k +: 4]);
      gg[k] = blk[1];
      gp[k] = blk[0];
    end
    gc  = cla4_carry(gp, gg, cin);
    blk = cla4_group(gp, gg);
    for (int k = 0; k < 4; k++) begin
      c[4*k +: 4] = cla4_carry(p[4*k +: 4], g[4*k +: 4], gc[k]);
    end
    return {blk[1] | (blk[0] & cin), p ^ c};
  endfunction

  // 32-bit half built from two chained 16-bit slices. Returns {carry_out, sum[31:0]}.
  function automatic logic [32:0] cla32(input logic [31:0] x, input logic [31:0] y,
                                        input logic cin);
    logic [16:0] lo;
    logic [16:0] hi;
    lo = cla16(x[15:0], y[15:0], cin);
    hi = cla16(x[31:16], y[31:16], lo[16]);
    return {hi, lo[15:0]};
  endfunction

  // Handshake / pipeline state
  logic                r_s1_valid;
  logic [LO_WIDTH-1:0] r_s1_diff_lo;
  logic                r_s1_c32;
  logic [HI_WIDTH-1:0] r_s1_a_hi;
  logic [HI_WIDTH-1:0] r_s1_y_hi;   // ~b[63:32] when subtracting, b[63:32] when adding
  logic                r_s1_b63;
`ifdef CLA_ADD_MODE_EN
  logic                r_s1_op;
`endif

  logic                r_out_valid;
  logic [WIDTH-1:0]    r_diff;
  logic                r_bout;
  logic                r_ovf;
  logic                r_zero;

  logic                w_s1_advance;
  logic                w_s2_advance;
  logic [WIDTH-1:0]    w_y;
  logic                w_cin;
  logic [LO_WIDTH:0]   w_lo;
  logic [HI_WIDTH:0]   w_hi;
  logic [WIDTH-1:0]    w_diff_nxt;
  logic                w_bout_nxt;
  logic                w_ovf_nxt;
  logic                w_zero_nxt;
  logic                w_a63;

  // Stall control: each stage moves when its downstream slot is free or draining.
  always_comb begin
    w_s2_advance = ~r_out_valid | out_ready;
    w_s1_advance = ~r_s1_valid | w_s2_advance;
  end

  assign in_ready = w_s1_advance;

  // Stage 1 operand conditioning and low-half carry look-ahead.
  always_comb begin
    w_y   = ~b;
    w_cin = ~bin;
`ifdef CLA_ADD_MODE_EN
    if (op) begin
      w_y   = b;
      w_cin = bin;
    end
`endif
    w_lo = cla32(a[LO_WIDTH-1:0], w_y[LO_WIDTH-1:0], w_cin);
  end

  // Stage 1 register: low-half result, c32 and the raw upper operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_diff_lo <= '0;
      r_s1_c32     <= 1'b0;
      r_s1_a_hi    <= '0;
      r_s1_y_hi    <= '0;
      r_s1_b63     <= 1'b0;
`ifdef CLA_ADD_MODE_EN
      r_s1_op      <= 1'b0;
`endif
    end else if (w_s1_advance) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_diff_lo <= w_lo[LO_WIDTH-1:0];
        r_s1_c32     <= w_lo[LO_WIDTH];
        r_s1_a_hi    <= a[WIDTH-1:LO_WIDTH];
        r_s1_y_hi    <= w_y[WIDTH-1:LO_WIDTH];
        r_s1_b63     <= b[WIDTH-1];
`ifdef CLA_ADD_MODE_EN
        r_s1_op      <= op;
`endif
      end
    end
  end

  // Stage 2 upper-half look-ahead and flag formation.
  always_comb begin
    w_hi       = cla32(r_s1_a_hi, r_s1_y_hi, r_s1_c32);
    w_diff_nxt = {w_hi[HI_WIDTH-1:0], r_s1_diff_lo};
    w_a63      = r_s1_a_hi[HI_WIDTH-1];
    w_bout_nxt = ~w_hi[HI_WIDTH];
    w_ovf_nxt  = (w_a63 != r_s1_b63) && (w_diff_nxt[WIDTH-1] != w_a63);
`ifdef CLA_ADD_MODE_EN
    if (r_s1_op) begin
      w_bout_nxt = w_hi[HI_WIDTH];
      w_ovf_nxt  = (w_a63 == r_s1_b63) && (w_diff_nxt[WIDTH-1] != w_a63);
    end
`endif
    w_zero_nxt = ~|w_diff_nxt;
  end

  // Stage 2 register: result and flags, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_diff      <= '0;
      r_bout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
    end else if (w_s2_advance) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_diff <= w_diff_nxt;
        r_bout <= w_bout_nxt;
        r_ovf  <= w_ovf_nxt;
        r_zero <= w_zero_nxt;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign diff      = r_diff;
  assign bout      = r_bout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule

// File: tb/tb_pipelined_64_bit_cla_subtractor.sv
// Self-checking bench for pipelined_64_bit_cla_subtractor: directed vectors with
// hand-derived results, a backpressure burst, mid-flight reset and randomized traffic
// scored against an arithmetic reference model.
module tb_pipelined_64_bit_cla_subtractor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        bin;
  logic        op;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] diff;
  logic        bout;
  logic        ovf;
  logic        zero;

  always #5 clk = ~clk;

  pipelined_64_bit_cla_subtractor #(
    .WIDTH    (64),
    .LO_WIDTH (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
`ifdef CLA_ADD_MODE_EN
    .op        (op),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .zero      (zero)
  );

  int          checks;
  int          errors;
  int          n_out;
  bit          saw_in_ready_low;
  logic [66:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [66:0] obs, input logic [66:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  // Expected result word: {diff, bout, ovf, zero}.
  function automatic logic [66:0] pack(input logic [63:0] d, input logic bo, input logic ov);
    return {d, bo, ov, (d == 64'd0)};
  endfunction

  // Plain-arithmetic reference: exact integer result, then wrap and overflow test.
  function automatic logic [66:0] model(input logic [63:0] ma, input logic [63:0] mb,
                                        input logic mbin, input logic mop);
    logic [64:0]        full;
    logic signed [65:0] sa;
    logic signed [65:0] sb;
    logic signed [65:0] sc;
    logic signed [65:0] s;
    logic               bo;
    sa = {{2{ma[63]}}, ma};
    sb = {{2{mb[63]}}, mb};
    sc = {65'd0, mbin};
    if (mop) begin
      full = {1'b0, ma} + {1'b0, mb} + {64'd0, mbin};
      bo   = full[64];
      s    = sa + sb + sc;
    end else begin
      full = {1'b0, ma} - {1'b0, mb} - {64'd0, mbin};
      bo   = ({1'b0, ma} < ({1'b0, mb} + {64'd0, mbin}));
      s    = sa - sb - sc;
    end
    return pack(full[63:0], bo, s[64] != s[63]);
  endfunction

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h7FFF_FFFF_FFFF_FFFF;
      4:       return {32'd0, $urandom()};
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  // One cycle: drive at negedge, observe 1ns later, score output and record input transfer.
  task automatic step(input logic v, input logic [63:0] ta, input logic [63:0] tb,
                      input logic tbin, input logic top, input logic tor,
                      input logic [66:0] texp, output logic fired);
    @(negedge clk);
    in_valid  = v;
    a         = ta;
    b         = tb;
    bin       = tbin;
    op        = top;
    out_ready = tor;
    #1;
    fired = in_valid && in_ready;
    if (!in_ready) saw_in_ready_low = 1'b1;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_out_valid", {66'd0, out_valid}, 67'd0);
      end else begin
        check_eq("result", {diff, bout, ovf, zero}, exp_q[0]);
        if (out_ready) begin
          void'(exp_q.pop_front());
          n_out++;
        end
      end
    end
    if (fired) exp_q.push_back(texp);
  endtask

  task automatic idle(input logic tor);
    logic f;
    step(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, tor, 67'd0, f);
  endtask

  task automatic send(input logic [63:0] ta, input logic [63:0] tb, input logic tbin,
                      input logic top, input logic [66:0] texp);
    logic f;
    int   n;
    f = 1'b0;
    n = 0;
    while (!f && n < 50) begin
      step(1'b1, ta, tb, tbin, top, 1'b1, texp, f);
      n++;
    end
    if (!f) check_eq("send_timeout", 67'd0, 67'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      idle(1'b1);
      n++;
    end
    check_eq("drain_empty", exp_q.size(), 67'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got running want finished");
    $fatal(1);
  end

  initial begin
    logic        f;
    logic [63:0] va[8];
    logic [63:0] vb[8];
    logic        vbin[8];
    int          i;
    int          c;
    int          n0;
    logic [63:0] ra;
    logic [63:0] rb;
    logic        rbin;
    logic        rop;

    checks    = 0;
    errors    = 0;
    n_out     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    op        = 1'b0;
    out_ready = 1'b1;

    // Reset state
    #1;
    check_eq("rst_outputs", {diff, bout, ovf, zero}, 67'd0);
    check_eq("rst_out_valid", {66'd0, out_valid}, 67'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst_in_ready", {66'd0, in_ready}, 67'd1);

    // 100 - 58 with latency check
    send(64'd100, 64'd58, 1'b0, 1'b0, pack(64'd42, 1'b0, 1'b0));
    idle(1'b1);
    check_eq("latency_c1", {66'd0, out_valid}, 67'd0);
    idle(1'b1);
    check_eq("latency_c2", {66'd0, out_valid}, 67'd1);
    drain();

    // Directed corners, back to back
    send(64'd0, 64'd1, 1'b0, 1'b0, pack(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0));
    send(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b0,
         pack(64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1));
    send(64'h0000_0001_0000_0000, 64'd1, 1'b0, 1'b0,
         pack(64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0));
    send(64'h0000_0001_0000_0000, 64'd1, 1'b1, 1'b0,
         pack(64'h0000_0000_FFFF_FFFE, 1'b0, 1'b0));
    send(64'd5, 64'd5, 1'b0, 1'b0, pack(64'd0, 1'b0, 1'b0));
    send(64'd0, 64'd0, 1'b1, 1'b0, pack(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0));
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0,
         pack(64'h8000_0000_0000_0000, 1'b1, 1'b1));
`ifdef CLA_ADD_MODE_EN
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1, pack(64'd0, 1'b1, 1'b0));
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1,
         pack(64'h8000_0000_0000_0000, 1'b0, 1'b1));
`endif
    drain();

    // Burst of 8 with the consumer stalled on cycles 3..6
    for (int k = 0; k < 8; k++) begin
      va[k]   = rnd64();
      vb[k]   = rnd64();
      vbin[k] = 1'($urandom_range(0, 1));
    end
    saw_in_ready_low = 1'b0;
    n0 = n_out;
    i  = 0;
    c  = 0;
    while (i < 8 && c < 100) begin
      step(1'b1, va[i], vb[i], vbin[i], 1'b0, !(c >= 3 && c <= 6),
           model(va[i], vb[i], vbin[i], 1'b0), f);
      if (f) i++;
      c++;
    end
    check_eq("burst_all_accepted", i, 67'd8);
    check_eq("burst_in_ready_dropped", {66'd0, saw_in_ready_low}, 67'd1);
    drain();
    check_eq("burst_count", n_out - n0, 67'd8);

    // Reset with two operations in flight
    send(64'd1000, 64'd1, 1'b0, 1'b0, pack(64'd999, 1'b0, 1'b0));
    send(64'd2000, 64'd2, 1'b0, 1'b0, pack(64'd1998, 1'b0, 1'b0));
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_eq("midrst_out_valid", {66'd0, out_valid}, 67'd0);
    check_eq("midrst_outputs", {diff, bout, ovf, zero}, 67'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("midrst_in_ready", {66'd0, in_ready}, 67'd1);
    n0 = n_out;
    repeat (6) idle(1'b1);
    check_eq("midrst_no_stale", n_out - n0, 67'd0);
    check_eq("midrst_idle_valid", {66'd0, out_valid}, 67'd0);

    // Randomized traffic with random backpressure
    for (int k = 0; k < 400; k++) begin
      ra   = rnd64();
      rb   = rnd64();
      rbin = 1'($urandom_range(0, 1));
      rop  = 1'b0;
`ifdef CLA_ADD_MODE_EN
      rop  = 1'($urandom_range(0, 1));
`endif
      step($urandom_range(0, 3) != 0, ra, rb, rbin, rop, $urandom_range(0, 3) != 0,
           model(ra, rb, rbin, rop), f);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
